// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between the data cache (D side)
// and the instruction prefetcher (I side). It also steers memory responses
// back to whichever side owns them.
//
// Ports:
//   clock, reset              rising-edge clock; asynchronous active-low reset
//   proc2Dmem_*               D-side request (command/addr/data/size)
//   proc2Imem_*               I-side request from the prefetcher
//   nuke                      pipeline flush; squashes I loads still in flight
//   mem2proc_response         nonzero = request accepted, value is its tag
//   mem2proc_data/_tag        returning data and its tag (0 = no return)
//   proc2mem_*                granted request forwarded to memory
//   Dmem2proc_*/Imem2proc_*   per-side acceptance response, data and tag
//   i_inflight                number of I-owned loads in flight
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned I_MAX_OUT    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [63:0] proc2Dmem_addr,
    input  logic [63:0] proc2Dmem_data,
    input  logic [1:0]  proc2Dmem_size,
    input  logic [1:0]  proc2Imem_command,
    input  logic [63:0] proc2Imem_addr,
    input  logic [63:0] proc2Imem_data,
    input  logic [1:0]  proc2Imem_size,
    input  logic        nuke,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic [1:0]  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    output logic [1:0]  proc2mem_size,
    output logic [3:0]  Dmem2proc_response,
    output logic [63:0] Dmem2proc_data,
    output logic [3:0]  Dmem2proc_tag,
    output logic [3:0]  Imem2proc_response,
    output logic [63:0] Imem2proc_data,
    output logic [3:0]  Imem2proc_tag,
    output logic [3:0]  i_inflight
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    // Owner table, one bit-vector per field, indexed by tag (entry 0 unused).
    // owner: 0 = D, 1 = I.
    logic [15:0]   tbl_valid, tbl_owner, tbl_squash;
    logic [15:0]   nxt_valid, nxt_owner, nxt_squash;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [3:0]    inflight_q, inflight_nxt;

    logic       d_req, i_elig, grant_d, grant_i, accepted, alloc;
    logic       ret_valid, ret_i;
    logic [1:0] grant_cmd;

    always_comb begin
        d_req     = (proc2Dmem_command != BUS_NONE);
        // Eligibility uses the registered count, so a return in this cycle
        // does not free a slot until the next one.
        i_elig    = (proc2Imem_command != BUS_NONE) && (inflight_q < 4'(I_MAX_OUT));
        grant_i   = i_elig && (!d_req || (starve_cnt >= SW'(STARVE_LIMIT)));
        grant_d   = d_req && !grant_i;
        grant_cmd = grant_i ? proc2Imem_command :
                    grant_d ? proc2Dmem_command : BUS_NONE;
        accepted  = (mem2proc_response != '0);
        alloc     = accepted && (grant_cmd == BUS_LOAD);
        ret_valid = (mem2proc_tag != '0) && tbl_valid[mem2proc_tag];
        ret_i     = ret_valid && tbl_owner[mem2proc_tag];
    end

    // Outputs; everything is forced to zero while reset is held.
    always_comb begin
        proc2mem_command   = BUS_NONE;
        proc2mem_addr      = '0;
        proc2mem_data      = '0;
        proc2mem_size      = '0;
        Dmem2proc_response = '0;
        Dmem2proc_data     = '0;
        Dmem2proc_tag      = '0;
        Imem2proc_response = '0;
        Imem2proc_data     = '0;
        Imem2proc_tag      = '0;
        i_inflight         = '0;
        if (reset) begin
            if (grant_i) begin
                proc2mem_command   = proc2Imem_command;
                proc2mem_addr      = proc2Imem_addr;
                proc2mem_data      = proc2Imem_data;
                proc2mem_size      = proc2Imem_size;
                Imem2proc_response = mem2proc_response;
            end else if (grant_d) begin
                proc2mem_command   = proc2Dmem_command;
                proc2mem_addr      = proc2Dmem_addr;
                proc2mem_data      = proc2Dmem_data;
                proc2mem_size      = proc2Dmem_size;
                Dmem2proc_response = mem2proc_response;
            end
            Dmem2proc_data = mem2proc_data;
            Imem2proc_data = mem2proc_data;
            if (ret_valid && !tbl_owner[mem2proc_tag])
                Dmem2proc_tag = mem2proc_tag;
            if (ret_i && !tbl_squash[mem2proc_tag])
                Imem2proc_tag = mem2proc_tag;
            i_inflight = inflight_q;
        end
    end

    // Next state. Ordering matters: the returning entry is cleared first,
    // nuke then squashes surviving I entries, and a new allocation on the
    // same tag overrides both.
    always_comb begin
        nxt_valid  = tbl_valid;
        nxt_owner  = tbl_owner;
        nxt_squash = tbl_squash;
        if (mem2proc_tag != '0) begin
            nxt_valid[mem2proc_tag]  = 1'b0;
            nxt_squash[mem2proc_tag] = 1'b0;
        end
        if (nuke)
            nxt_squash = nxt_squash | (nxt_valid & nxt_owner);
        if (alloc) begin
            nxt_valid[mem2proc_response]  = 1'b1;
            nxt_owner[mem2proc_response]  = grant_i;
            nxt_squash[mem2proc_response] = nuke && grant_i;
        end

        inflight_nxt = inflight_q + {3'b000, alloc && grant_i} - {3'b000, ret_i};

        starve_nxt = starve_cnt;
        if (!i_elig)
            starve_nxt = '0;
        else if (accepted && grant_i)
            starve_nxt = '0;
        else if (accepted && grant_d && (starve_cnt < SW'(STARVE_LIMIT)))
            starve_nxt = starve_cnt + SW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tbl_valid  <= '0;
            tbl_owner  <= '0;
            tbl_squash <= '0;
            starve_cnt <= '0;
            inflight_q <= '0;
        end else begin
            tbl_valid  <= nxt_valid;
            tbl_owner  <= nxt_owner;
            tbl_squash <= nxt_squash;
            starve_cnt <= starve_nxt;
            inflight_q <= inflight_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, a mid-flight asynchronous reset
// sequence, then randomized traffic checked against a tag-ownership model.
module tb_mem_arbiter;

    localparam int unsigned LIM  = 4;
    localparam int unsigned IMAX = 2;

    localparam logic [63:0] D_ADDR  = 64'h0000_D0D0_0000_1000;
    localparam logic [63:0] D_WDATA = 64'h1111_2222_3333_4444;
    localparam logic [1:0]  D_SIZE  = 2'd3;
    localparam logic [63:0] I_ADDR  = 64'h0000_1C1C_0000_2000;
    localparam logic [63:0] I_WDATA = 64'h5555_6666_7777_8888;
    localparam logic [1:0]  I_SIZE  = 2'd2;

    logic        clock, reset;
    logic [1:0]  proc2Dmem_command, proc2Dmem_size, proc2Imem_command, proc2Imem_size;
    logic [63:0] proc2Dmem_addr, proc2Dmem_data, proc2Imem_addr, proc2Imem_data;
    logic        nuke;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic [1:0]  proc2mem_command, proc2mem_size;
    logic [63:0] proc2mem_addr, proc2mem_data;
    logic [3:0]  Dmem2proc_response, Dmem2proc_tag, Imem2proc_response, Imem2proc_tag;
    logic [63:0] Dmem2proc_data, Imem2proc_data;
    logic [3:0]  i_inflight;

    mem_arbiter #(.STARVE_LIMIT(LIM), .I_MAX_OUT(IMAX)) dut (
        .clock(clock), .reset(reset),
        .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
        .proc2Dmem_data(proc2Dmem_data), .proc2Dmem_size(proc2Dmem_size),
        .proc2Imem_command(proc2Imem_command), .proc2Imem_addr(proc2Imem_addr),
        .proc2Imem_data(proc2Imem_data), .proc2Imem_size(proc2Imem_size),
        .nuke(nuke), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
        .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
        .Dmem2proc_tag(Dmem2proc_tag),
        .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
        .Imem2proc_tag(Imem2proc_tag),
        .i_inflight(i_inflight)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_own: 0 = no load outstanding on this tag, 1 = D owns it, 2 = I owns it.
    int unsigned m_own [16];
    bit          m_sq  [16];
    int unsigned m_starve;
    bit          m_ielig;

    int unsigned e_fwd;
    logic [1:0]  e_cmd, e_size;
    logic [63:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_dresp, e_iresp, e_dtag, e_itag, e_infl;

    function automatic int unsigned m_count();
        int unsigned n = 0;
        foreach (m_own[t]) if (m_own[t] == 2) n++;
        return n;
    endfunction

    task automatic model_reset();
        foreach (m_own[t]) begin
            m_own[t] = 0;
            m_sq[t]  = 1'b0;
        end
        m_starve = 0;
    endtask

    task automatic predict();
        bit d_req;
        e_fwd = 0; e_cmd = '0; e_addr = '0; e_wdata = '0; e_size = '0;
        e_dresp = '0; e_iresp = '0; e_dtag = '0; e_itag = '0; e_infl = '0; e_rdata = '0;
        d_req   = (proc2Dmem_command != 2'd0);
        m_ielig = (proc2Imem_command != 2'd0) && (m_count() < IMAX);
        if (!reset) return;
        if (m_ielig && (!d_req || m_starve >= LIM)) e_fwd = 2;
        else if (d_req) e_fwd = 1;
        if (e_fwd == 1) begin
            e_cmd = proc2Dmem_command; e_addr = proc2Dmem_addr;
            e_wdata = proc2Dmem_data; e_size = proc2Dmem_size; e_dresp = mem2proc_response;
        end else if (e_fwd == 2) begin
            e_cmd = proc2Imem_command; e_addr = proc2Imem_addr;
            e_wdata = proc2Imem_data; e_size = proc2Imem_size; e_iresp = mem2proc_response;
        end
        e_rdata = mem2proc_data;
        if (mem2proc_tag != 0) begin
            if (m_own[mem2proc_tag] == 1) e_dtag = mem2proc_tag;
            if (m_own[mem2proc_tag] == 2 && !m_sq[mem2proc_tag]) e_itag = mem2proc_tag;
        end
        e_infl = 4'(m_count());
    endtask

    task automatic model_edge();
        int unsigned acc;
        acc = mem2proc_response;
        if (mem2proc_tag != 0) begin
            m_own[mem2proc_tag] = 0;
            m_sq[mem2proc_tag]  = 1'b0;
        end
        if (nuke) foreach (m_own[t]) if (m_own[t] == 2) m_sq[t] = 1'b1;
        if (acc != 0 && e_fwd != 0 && e_cmd == 2'd1) begin
            m_own[acc] = e_fwd;
            m_sq[acc]  = nuke && (e_fwd == 2);
        end
        if (!m_ielig) m_starve = 0;
        else if (acc != 0 && e_fwd == 2) m_starve = 0;
        else if (acc != 0 && e_fwd == 1 && m_starve < LIM) m_starve++;
    endtask

    task automatic compare_all(input string lbl);
        check({lbl, ".cmd"},   64'(proc2mem_command),   64'(e_cmd));
        check({lbl, ".addr"},  proc2mem_addr,           e_addr);
        check({lbl, ".wdata"}, proc2mem_data,           e_wdata);
        check({lbl, ".size"},  64'(proc2mem_size),      64'(e_size));
        check({lbl, ".dresp"}, 64'(Dmem2proc_response), 64'(e_dresp));
        check({lbl, ".iresp"}, 64'(Imem2proc_response), 64'(e_iresp));
        check({lbl, ".dtag"},  64'(Dmem2proc_tag),      64'(e_dtag));
        check({lbl, ".itag"},  64'(Imem2proc_tag),      64'(e_itag));
        check({lbl, ".ddata"}, Dmem2proc_data,          e_rdata);
        check({lbl, ".idata"}, Imem2proc_data,          e_rdata);
        check({lbl, ".infl"},  64'(i_inflight),         64'(e_infl));
    endtask

    // Inputs are set just after a rising edge; outputs are sampled mid-cycle.
    task automatic step_model(input string lbl);
        #4;
        predict();
        compare_all(lbl);
        if (!reset) model_reset();
        else model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        proc2Dmem_command = 2'd0; proc2Imem_command = 2'd0;
        proc2Dmem_addr = D_ADDR; proc2Dmem_data = D_WDATA; proc2Dmem_size = D_SIZE;
        proc2Imem_addr = I_ADDR; proc2Imem_data = I_WDATA; proc2Imem_size = I_SIZE;
        nuke = 1'b0; mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  dcmd, icmd;
        logic        nk;
        logic [3:0]  resp, rtag;
        logic [63:0] rdata;
        int unsigned fwd;       // 0 none, 1 D, 2 I
        logic [3:0]  dresp, iresp, dtag, itag, infl;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic [1:0] dcmd, input logic [1:0] icmd, input logic nk,
                       input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata,
                       input int unsigned fwd, input logic [3:0] dresp, input logic [3:0] iresp,
                       input logic [3:0] dtag, input logic [3:0] itag, input logic [3:0] infl);
        vec_t v;
        v.dcmd = dcmd; v.icmd = icmd; v.nk = nk; v.resp = resp; v.rtag = rtag; v.rdata = rdata;
        v.fwd = fwd; v.dresp = dresp; v.iresp = iresp; v.dtag = dtag; v.itag = itag; v.infl = infl;
        vt.push_back(v);
    endtask

    localparam logic [1:0] N = 2'd0, L = 2'd1, S = 2'd2;

    initial begin
        logic [1:0]  x_cmd, x_size;
        logic [63:0] x_addr, x_wdata;
        logic [3:0]  t, r;

        // D-only load, tag 3 returns five cycles later
        add(L, N, 0,  3,  0, 64'h0,      1,  3,  0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(N, N, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0);
        add(N, N, 0,  0,  3, 64'hDEAD,   0,  0,  0, 3, 0, 0);
        // store allocates nothing
        add(S, N, 0,  7,  0, 64'h0,      1,  7,  0, 0, 0, 0);
        add(N, N, 0,  0,  7, 64'h5707,   0,  0,  0, 0, 0, 0);
        // nuke squash of tags 5 and 6
        add(N, L, 0,  5,  0, 64'h0,      2,  0,  5, 0, 0, 0);
        add(N, L, 0,  6,  0, 64'h0,      2,  0,  6, 0, 0, 1);
        add(N, N, 1,  0,  0, 64'h0,      0,  0,  0, 0, 0, 2);
        add(N, N, 0,  0,  5, 64'h55,     0,  0,  0, 0, 0, 2);
        add(N, N, 0,  0,  6, 64'h66,     0,  0,  0, 0, 0, 1);
        add(N, N, 0,  0,  0, 64'h0,      0,  0,  0, 0, 0, 0);
        // throttle at IMAX=2; a return re-enables I only a cycle later
        add(N, L, 0,  1,  0, 64'h0,      2,  0,  1, 0, 0, 0);
        add(N, L, 0,  2,  0, 64'h0,      2,  0,  2, 0, 0, 1);
        add(N, L, 0,  0,  0, 64'h0,      0,  0,  0, 0, 0, 2);
        add(N, L, 0,  0,  1, 64'hBEEF,   0,  0,  0, 0, 1, 2);
        add(N, L, 0,  4,  0, 64'h0,      2,  0,  4, 0, 0, 1);
        add(N, L, 0,  0,  2, 64'h22,     0,  0,  0, 0, 2, 2);
        add(N, N, 0,  0,  4, 64'h44,     0,  0,  0, 0, 4, 1);
        // starvation: D x4, I, D
        add(L, L, 0,  8,  0, 64'h0,      1,  8,  0, 0, 0, 0);
        add(L, L, 0,  9,  0, 64'h0,      1,  9,  0, 0, 0, 0);
        add(L, L, 0, 10,  0, 64'h0,      1, 10,  0, 0, 0, 0);
        add(L, L, 0, 11,  0, 64'h0,      1, 11,  0, 0, 0, 0);
        add(L, L, 0, 12,  0, 64'h0,      2,  0, 12, 0, 0, 0);
        add(L, L, 0, 13,  0, 64'h0,      1, 13,  0, 0, 0, 1);
        add(L, L, 0,  0,  0, 64'h0,      1,  0,  0, 0, 0, 1);
        // tag 8 returned (D) and reallocated to I in the same cycle
        add(N, L, 0,  8,  8, 64'h88,     2,  0,  8, 8, 0, 1);
        add(N, N, 0,  0,  8, 64'h888,    0,  0,  0, 0, 8, 2);
        // nuke together with an accepted I load
        add(N, L, 1, 14,  0, 64'h0,      2,  0, 14, 0, 0, 1);
        add(N, N, 0,  0, 14, 64'hE,      0,  0,  0, 0, 0, 2);
        add(N, N, 0,  0, 12, 64'hC,      0,  0,  0, 0, 0, 1);
        add(N, N, 0,  0,  9, 64'h9,      0,  0,  0, 9, 0, 0);
        add(N, N, 0,  0, 15, 64'hF,      0,  0,  0, 0, 0, 0);

        idle_inputs();
        model_reset();
        reset = 1'b0;
        #2;
        check("reset.cmd",  64'(proc2mem_command), 64'd0);
        check("reset.infl", 64'(i_inflight),       64'd0);
        @(posedge clock); @(posedge clock);
        #1 reset = 1'b1;

        foreach (vt[k]) begin
            proc2Dmem_command = vt[k].dcmd;
            proc2Imem_command = vt[k].icmd;
            nuke              = vt[k].nk;
            mem2proc_response = vt[k].resp;
            mem2proc_tag      = vt[k].rtag;
            mem2proc_data     = vt[k].rdata;
            #4;
            predict();
            x_cmd = 2'd0; x_addr = '0; x_wdata = '0; x_size = '0;
            if (vt[k].fwd == 1) begin
                x_cmd = vt[k].dcmd; x_addr = D_ADDR; x_wdata = D_WDATA; x_size = D_SIZE;
            end else if (vt[k].fwd == 2) begin
                x_cmd = vt[k].icmd; x_addr = I_ADDR; x_wdata = I_WDATA; x_size = I_SIZE;
            end
            check($sformatf("vec%0d.cmd", k),   64'(proc2mem_command),   64'(x_cmd));
            check($sformatf("vec%0d.addr", k),  proc2mem_addr,           x_addr);
            check($sformatf("vec%0d.wdata", k), proc2mem_data,           x_wdata);
            check($sformatf("vec%0d.size", k),  64'(proc2mem_size),      64'(x_size));
            check($sformatf("vec%0d.dresp", k), 64'(Dmem2proc_response), 64'(vt[k].dresp));
            check($sformatf("vec%0d.iresp", k), 64'(Imem2proc_response), 64'(vt[k].iresp));
            check($sformatf("vec%0d.dtag", k),  64'(Dmem2proc_tag),      64'(vt[k].dtag));
            check($sformatf("vec%0d.itag", k),  64'(Imem2proc_tag),      64'(vt[k].itag));
            check($sformatf("vec%0d.ddata", k), Dmem2proc_data,          vt[k].rdata);
            check($sformatf("vec%0d.idata", k), Imem2proc_data,          vt[k].rdata);
            check($sformatf("vec%0d.infl", k),  64'(i_inflight),         64'(vt[k].infl));
            model_edge();
            @(posedge clock);
            #1;
        end

        // Reset mid-flight: D tags 10, 11, 13 still outstanding, add I tag 5.
        idle_inputs();
        proc2Imem_command = L; mem2proc_response = 4'd5;
        step_model("pre_rst");
        idle_inputs();
        #2;
        check("pre_rst.infl", 64'(i_inflight), 64'd1);
        proc2Dmem_command = L; mem2proc_response = 4'd3;
        reset = 1'b0;
        #1;
        check("rst_async.infl",  64'(i_inflight),         64'd0);
        check("rst_async.cmd",   64'(proc2mem_command),   64'd0);
        check("rst_async.dresp", 64'(Dmem2proc_response), 64'd0);
        check("rst_async.addr",  proc2mem_addr,           64'd0);
        model_reset();
        @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1 idle_inputs();
        mem2proc_tag = 4'd5; mem2proc_data = 64'hAAAA;
        step_model("post_rst5");
        mem2proc_tag = 4'd10; mem2proc_data = 64'hBBBB;
        step_model("post_rst10");

        // Randomized traffic against the model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            case ($urandom_range(0, 3))
                0:       proc2Dmem_command = N;
                3:       proc2Dmem_command = S;
                default: proc2Dmem_command = L;
            endcase
            case ($urandom_range(0, 7))
                0, 1, 2: proc2Imem_command = N;
                3:       proc2Imem_command = S;
                default: proc2Imem_command = L;
            endcase
            proc2Dmem_addr = {$urandom, $urandom}; proc2Dmem_data = {$urandom, $urandom};
            proc2Imem_addr = {$urandom, $urandom}; proc2Imem_data = {$urandom, $urandom};
            proc2Dmem_size = 2'($urandom_range(0, 3));
            proc2Imem_size = 2'($urandom_range(0, 3));
            nuke = ($urandom_range(0, 15) == 0);
            mem2proc_data = {$urandom, $urandom};
            t = 4'($urandom_range(1, 15));
            mem2proc_tag = '0;
            if ($urandom_range(0, 1) == 1 && (m_own[t] != 0 || $urandom_range(0, 3) == 0))
                mem2proc_tag = t;
            // Memory only hands out a tag that is free or being returned now.
            r = 4'($urandom_range(1, 15));
            mem2proc_response = '0;
            if ((m_own[r] == 0 || r == mem2proc_tag) && $urandom_range(0, 3) != 0)
                mem2proc_response = r;
            step_model($sformatf("rnd%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
